// File: rtl/output_port_arbiter_cluster_if.sv
// Handshake bundle for the output port arbiter cluster. It carries the user
// payload/valid/ack side and the merged packet valid/ready side.
interface output_port_arbiter_cluster_if #(
  parameter int NUM_OUT_PORTS = 7,
  parameter int PAYLOAD_BITS  = 64,
  parameter int PACKET_BITS   = 82
);
  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0] din;
  logic [NUM_OUT_PORTS-1:0]              vld;
  logic [NUM_OUT_PORTS-1:0]              ack;
  logic [PACKET_BITS-1:0]                pkt_out;
  logic                                  pkt_vld;
  logic                                  pkt_rdy;

  // The user/sink side drives payloads and packet ready.
  modport master (output din, vld, pkt_rdy, input ack, pkt_out, pkt_vld);
  // The cluster accepts payloads and presents packets.
  modport slave  (input din, vld, pkt_rdy, output ack, pkt_out, pkt_vld);
endinterface

// File: rtl/output_port_arbiter_cluster.sv
// Output port arbiter cluster: buffers NUM_OUT_PORTS payload streams in small
// FIFOs, wraps each payload in a BFT header, tracks destination credits and
// merges all ports round-robin onto one registered valid/ready packet output.
module output_port_arbiter_cluster #(
  parameter int NUM_OUT_PORTS   = 7,
  parameter int PAYLOAD_BITS    = 64,
  parameter int NUM_LEAF_BITS   = 6,
  parameter int NUM_PORT_BITS   = 4,
  parameter int NUM_ADDR_BITS   = 7,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int CNT_BITS        = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              cfg_wr_en,
  input  logic [3:0]                        cfg_port_sel,
  input  logic [NUM_LEAF_BITS-1:0]          cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]          cfg_dst_port,
  input  logic [NUM_ADDR_BITS:0]            cfg_credit_init,
  input  logic                              credit_ret_en,
  input  logic [3:0]                        credit_ret_port,
  input  logic [NUM_ADDR_BITS:0]            credit_ret_amt,
  output_port_arbiter_cluster_if.slave      bus,
  output logic [CNT_BITS*NUM_OUT_PORTS-1:0] stall_cnt,
  output logic                              stall_any
);
  localparam int PACKET_BITS = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
  localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
  localparam int CW    = NUM_ADDR_BITS + 1;
  localparam int PW    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CW-1:0]              CREDIT_MAX = CW'(2 ** NUM_ADDR_BITS);
  localparam logic [FIFO_DEPTH_BITS:0]   COUNT_FULL = (FIFO_DEPTH_BITS+1)'(DEPTH);

  logic [PAYLOAD_BITS-1:0]    mem_q    [NUM_OUT_PORTS][DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q [NUM_OUT_PORTS];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_d [NUM_OUT_PORTS];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q [NUM_OUT_PORTS];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_d [NUM_OUT_PORTS];
  logic [FIFO_DEPTH_BITS:0]   count_q  [NUM_OUT_PORTS];
  logic [FIFO_DEPTH_BITS:0]   count_d  [NUM_OUT_PORTS];
  logic [CW-1:0]              credit_q [NUM_OUT_PORTS];
  logic [CW-1:0]              credit_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]   addr_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]   addr_d   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]   leaf_q   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]   leaf_d   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]   dport_q  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]   dport_d  [NUM_OUT_PORTS];
  logic [CNT_BITS-1:0]        scnt_q   [NUM_OUT_PORTS];
  logic [CNT_BITS-1:0]        scnt_d   [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0]   en_q, en_d;
  logic [PW-1:0]              rr_q, rr_d;
  logic [PACKET_BITS-1:0]     pkt_q, pkt_d;
  logic                       pkt_vld_q, pkt_vld_d;
  logic                       stall_any_q, stall_any_d;

  logic [NUM_OUT_PORTS-1:0] full, empty, elig, stall, push, pop, cfg_hit, ret_hit;
  logic                     load, gnt_found;
  logic [PW-1:0]            gnt_idx;

  // Credit after an optional grant and optional return, clamped to the
  // destination FIFO size. A grant only happens with credit != 0, so no underflow.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur, input logic dec,
                                                input logic inc_en, input logic [CW-1:0] amt);
    logic [CW+1:0] sum;
    sum = {2'b00, cur} + (inc_en ? {2'b00, amt} : '0) - (CW+2)'(dec);
    if (sum > {2'b00, CREDIT_MAX}) return CREDIT_MAX;
    return sum[CW-1:0];
  endfunction

  // Stall counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  // Per-port status decoded from registered FIFO/credit state.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      full[i]    = (count_q[i] == COUNT_FULL);
      empty[i]   = (count_q[i] == '0);
      elig[i]    = en_q[i] & ~empty[i] & (credit_q[i] != '0);
      stall[i]   = en_q[i] & ~empty[i] & (credit_q[i] == '0);
      push[i]    = bus.vld[i] & ~full[i];
      cfg_hit[i] = cfg_wr_en & (cfg_port_sel == 4'(i));
      ret_hit[i] = credit_ret_en & (credit_ret_port == 4'(i));
    end
  end

  // Round-robin search: first eligible port at or above rr_q, then wrap below it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!gnt_found && elig[i] && (PW'(i) >= rr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!gnt_found && elig[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
  end

  // Next state for the output register, RR pointer and per-port bookkeeping.
  always_comb begin
    load        = ~pkt_vld_q | bus.pkt_rdy;
    pkt_d       = pkt_q;
    pkt_vld_d   = pkt_vld_q;
    rr_d        = rr_q;
    stall_any_d = |stall;
    if (load) begin
      pkt_vld_d = gnt_found;
      if (gnt_found) begin
        pkt_d = {1'b1, leaf_q[gnt_idx], dport_q[gnt_idx], addr_q[gnt_idx],
                 mem_q[gnt_idx][rd_ptr_q[gnt_idx]]};
        rr_d  = (gnt_idx == PW'(NUM_OUT_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
      end
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      pop[i]      = load & gnt_found & (gnt_idx == PW'(i));
      wr_ptr_d[i] = wr_ptr_q[i] + FIFO_DEPTH_BITS'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + FIFO_DEPTH_BITS'(pop[i]);
      count_d[i]  = count_q[i] + (FIFO_DEPTH_BITS+1)'(push[i]) - (FIFO_DEPTH_BITS+1)'(pop[i]);
      scnt_d[i]   = stall[i] ? sat_inc(scnt_q[i]) : scnt_q[i];
      leaf_d[i]   = leaf_q[i];
      dport_d[i]  = dport_q[i];
      en_d[i]     = en_q[i];
      // Configuration overrides any same-cycle grant or return bookkeeping.
      if (cfg_hit[i]) begin
        leaf_d[i]   = cfg_dst_leaf;
        dport_d[i]  = cfg_dst_port;
        credit_d[i] = cfg_credit_init;
        addr_d[i]   = '0;
        en_d[i]     = 1'b1;
      end else begin
        credit_d[i] = credit_next(credit_q[i], pop[i], ret_hit[i], credit_ret_amt);
        addr_d[i]   = pop[i] ? addr_q[i] + NUM_ADDR_BITS'(1) : addr_q[i];
      end
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.din[PAYLOAD_BITS*i +: PAYLOAD_BITS];
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        credit_q[i] <= '0;
        addr_q[i]   <= '0;
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
        scnt_q[i]   <= '0;
      end
      en_q        <= '0;
      rr_q        <= '0;
      pkt_q       <= '0;
      pkt_vld_q   <= 1'b0;
      stall_any_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
        credit_q[i] <= credit_d[i];
        addr_q[i]   <= addr_d[i];
        leaf_q[i]   <= leaf_d[i];
        dport_q[i]  <= dport_d[i];
        scnt_q[i]   <= scnt_d[i];
      end
      en_q        <= en_d;
      rr_q        <= rr_d;
      pkt_q       <= pkt_d;
      pkt_vld_q   <= pkt_vld_d;
      stall_any_q <= stall_any_d;
    end
  end

  // Flatten the stall counters onto the readback bus.
  always_comb begin
    stall_cnt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      stall_cnt[CNT_BITS*i +: CNT_BITS] = scnt_q[i];
    end
  end

  assign bus.ack     = ~full;
  assign bus.pkt_out = pkt_q;
  assign bus.pkt_vld = pkt_vld_q;
  assign stall_any   = stall_any_q;
endmodule

// File: tb/tb_output_port_arbiter_cluster.sv
// Scoreboard bench for output_port_arbiter_cluster: directed stimulus pushes
// expected packets into a queue; a negedge monitor pops and compares every
// packet the DUT hands over.
module tb_output_port_arbiter_cluster;
  localparam int N   = 7;
  localparam int PB  = 64;
  localparam int LB  = 6;
  localparam int PTB = 4;
  localparam int AB  = 7;
  localparam int FDB = 2;
  localparam int CB  = 32;
  localparam int PKB = 1 + LB + PTB + AB + PB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [3:0]    cfg_port_sel = '0;
  logic [LB-1:0] cfg_dst_leaf = '0;
  logic [PTB-1:0] cfg_dst_port = '0;
  logic [AB:0]   cfg_credit_init = '0;
  logic          credit_ret_en = 1'b0;
  logic [3:0]    credit_ret_port = '0;
  logic [AB:0]   credit_ret_amt = '0;
  logic [CB*N-1:0] stall_cnt;
  logic          stall_any;

  output_port_arbiter_cluster_if #(.NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .PACKET_BITS(PKB)) bus();

  output_port_arbiter_cluster #(
    .NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PTB),
    .NUM_ADDR_BITS(AB), .FIFO_DEPTH_BITS(FDB), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_wr_en(cfg_wr_en), .cfg_port_sel(cfg_port_sel), .cfg_dst_leaf(cfg_dst_leaf),
    .cfg_dst_port(cfg_dst_port), .cfg_credit_init(cfg_credit_init),
    .credit_ret_en(credit_ret_en), .credit_ret_port(credit_ret_port),
    .credit_ret_amt(credit_ret_amt),
    .bus(bus), .stall_cnt(stall_cnt), .stall_any(stall_any)
  );

  always #5 clk = ~clk;

  logic [PKB-1:0] exp_q[$];
  logic [PKB-1:0] mon_exp;
  logic [PKB-1:0] hold_pkt;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PKB-1:0] mkpkt(input int leaf, input int dp, input int addr,
                                           input logic [PB-1:0] pl);
    return {1'b1, LB'(leaf), PTB'(dp), AB'(addr), pl};
  endfunction

  // Monitor: every accepted packet must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && bus.pkt_vld && bus.pkt_rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pkt: got %0h, expected no packet (t=%0t)", bus.pkt_out, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pkt", bus.pkt_out, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic cfg(input int p, input int leaf, input int dp, input int cr);
    cfg_wr_en = 1'b1;
    cfg_port_sel = 4'(p);
    cfg_dst_leaf = LB'(leaf);
    cfg_dst_port = PTB'(dp);
    cfg_credit_init = (AB+1)'(cr);
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic ret(input int p, input int amt);
    credit_ret_en = 1'b1;
    credit_ret_port = 4'(p);
    credit_ret_amt = (AB+1)'(amt);
    tick();
    credit_ret_en = 1'b0;
  endtask

  task automatic push_raw(input int p, input logic [PB-1:0] d);
    bus.din[PB*p +: PB] = d;
    bus.vld[p] = 1'b1;
    tick();
    bus.vld[p] = 1'b0;
  endtask

  task automatic push(input int p, input logic [PB-1:0] d);
    int w;
    w = 0;
    while (!bus.ack[p] && w < 20) begin
      tick();
      w++;
    end
    if (!bus.ack[p]) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_wait: port %0d ack stayed 0, expected 1", p);
    end
    push_raw(p, d);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      tick();
      w++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.din = '0;
    bus.vld = '0;
    bus.pkt_rdy = 1'b1;

    // Reset values
    tick();
    tick();
    check("rst_pkt_vld", bus.pkt_vld, 0);
    check("rst_ack", bus.ack, 7'h7F);
    check("rst_pkt_out", bus.pkt_out, 0);
    check("rst_stall_any", stall_any, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    reset_n = 1'b1;

    // Single packet and its latency
    cfg(0, 3, 2, 4);
    exp_q.push_back(mkpkt(3, 2, 0, 64'hA5));
    push_raw(0, 64'hA5);
    check("lat_t1_vld", bus.pkt_vld, 0);
    tick();
    check("lat_t2_vld", bus.pkt_vld, 1);
    check("lat_t2_pkt", bus.pkt_out, {1'b1, 6'd3, 4'd2, 7'd0, 64'hA5});
    drain("single");

    // Round robin across ports 0..2, per-port addresses 0,1,2
    do_reset();
    cfg(0, 1, 1, 8);
    cfg(1, 2, 3, 8);
    cfg(2, 4, 5, 8);
    bus.pkt_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 3; p++) begin
        exp_q.push_back(mkpkt((p == 0) ? 1 : (p == 1) ? 2 : 4, (p == 0) ? 1 : (p == 1) ? 3 : 5,
                              k, 64'h100 + 64'(16 * k + p)));
        bus.din[PB*p +: PB] = 64'h100 + 64'(16 * k + p);
      end
      bus.vld = 7'b0000111;
      tick();
      bus.vld = '0;
    end
    bus.pkt_rdy = 1'b1;
    drain("rr");

    // Credit exhaustion, stall counting, return
    do_reset();
    cfg(0, 5, 7, 2);
    exp_q.push_back(mkpkt(5, 7, 0, 64'hC0));
    exp_q.push_back(mkpkt(5, 7, 1, 64'hC1));
    exp_q.push_back(mkpkt(5, 7, 2, 64'hC2));
    push_raw(0, 64'hC0);
    push_raw(0, 64'hC1);
    push_raw(0, 64'hC2);
    check("stall_cnt_start", stall_cnt[CB*0 +: CB], 0);
    check("stall_any_start", stall_any, 0);
    tick();
    check("stall_cnt_1", stall_cnt[CB*0 +: CB], 1);
    check("stall_any_on", stall_any, 1);
    repeat (4) tick();
    check("stall_cnt_5", stall_cnt[CB*0 +: CB], 5);
    ret(0, 1);
    tick();
    check("stall_cnt_frozen", stall_cnt[CB*0 +: CB], 6);
    check("stall_any_off", stall_any, 0);
    repeat (3) tick();
    check("stall_cnt_frozen2", stall_cnt[CB*0 +: CB], 6);
    drain("credit");

    // FIFO full on a disabled port, drop, backpressure hold
    do_reset();
    bus.pkt_rdy = 1'b0;
    for (int k = 0; k < 4; k++) push_raw(3, 64'hD0 + 64'(k));
    check("full_ack", bus.ack, 7'b1110111);
    check("disabled_no_stall", stall_any, 0);
    push_raw(3, 64'hDEAD);
    check("full_ack_after_drop", bus.ack, 7'b1110111);
    for (int k = 0; k < 4; k++) exp_q.push_back(mkpkt(9, 3, k, 64'hD0 + 64'(k)));
    cfg(3, 9, 3, 16);
    tick();
    hold_pkt = mkpkt(9, 3, 0, 64'hD0);
    for (int c = 0; c < 5; c++) begin
      check("hold_vld", bus.pkt_vld, 1);
      check("hold_pkt", bus.pkt_out, hold_pkt);
      tick();
    end
    check("ack_after_pop", bus.ack[3], 1);
    bus.pkt_rdy = 1'b1;
    drain("hold");
    repeat (3) tick();
    check("no_extra_pkt", bus.pkt_vld, 0);

    // Same-cycle grant and return; then saturation at 128
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_raw(4, 64'hE0 + 64'(k));
      exp_q.push_back(mkpkt(12, 9, k, 64'hE0 + 64'(k)));
    end
    cfg(4, 12, 9, 1);
    ret(4, 3);
    push(4, 64'hE4);
    drain("grant_ret");
    repeat (3) tick();
    check("gr_stop_vld", bus.pkt_vld, 0);
    check("gr_stall_any", stall_any, 1);
    exp_q.push_back(mkpkt(12, 9, 4, 64'hE4));
    ret(4, 255);
    for (int n = 1; n <= 128; n++) begin
      if (n < 128) exp_q.push_back(mkpkt(12, 9, (4 + n) % 128, 64'h5000 + 64'(n)));
      push(4, 64'h5000 + 64'(n));
    end
    drain("sat");
    repeat (3) tick();
    check("sat_stop_vld", bus.pkt_vld, 0);
    check("sat_stall_any", stall_any, 1);

    // Asynchronous reset while a packet is held
    bus.pkt_rdy = 1'b0;
    ret(4, 1);
    tick();
    check("pre_rst_vld", bus.pkt_vld, 1);
    check("pre_rst_pkt", bus.pkt_out, mkpkt(12, 9, 4, 64'h5000 + 64'(128)));
    for (int k = 0; k < 4; k++) push_raw(5, 64'hF0 + 64'(k));
    check("pre_rst_ack", bus.ack, 7'b1011111);
    check("pre_rst_cnt_nz", stall_cnt[CB*4 +: CB] != 0, 1);
    exp_q.delete();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_vld", bus.pkt_vld, 0);
    check("async_rst_ack", bus.ack, 7'h7F);
    check("async_rst_cnt", stall_cnt, 0);
    check("async_rst_any", stall_any, 0);
    check("async_rst_pkt", bus.pkt_out, 0);
    #20;
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
